// File: rtl/bitstream_pkg.sv
// -----------------------------------------------------------------------------
// bitstream_pkg
//   Definitions shared by the serial-link serializer and deserializer:
//   FSM state encodings and the default word width.
//   No ports (package only).
// -----------------------------------------------------------------------------
package bitstream_pkg;

    // Kept as plain 4-bit constants so older RTL can compare against them directly.
    localparam logic [3:0] ST_RST     = 4'd0;
    localparam logic [3:0] ST_IDLE    = 4'd1;
    localparam logic [3:0] ST_COLLECT = 4'd2;

    localparam int BITSTREAM_WORD = 8;

endpackage : bitstream_pkg

// File: rtl/bitstream_gap_timer.sv
// -----------------------------------------------------------------------------
// bitstream_gap_timer
//   Counts consecutive enabled cycles and flags the cycle in which the
//   TIMEOUT_CYCLES-th one occurs. The count runs down from TIMEOUT_CYCLES-1,
//   so the terminal pulse is a simple compare against zero.
//
// Ports
//   clk     in   clock, posedge
//   rst     in   synchronous, active-high reset (reloads the counter)
//   clr_i   in   reload the counter (takes priority over en_i)
//   en_i    in   count this cycle
//   tc_o    out  combinational pulse: this enabled cycle is the last one
// -----------------------------------------------------------------------------
module bitstream_gap_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= LOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && !clr_i && (cnt_q == '0);

endmodule : bitstream_gap_timer

// File: rtl/bitstream_to_byte.sv
// -----------------------------------------------------------------------------
// bitstream_to_byte
//   Receive-side deserializer. Rebuilds OUT_SIZE-bit words from an LSB-first
//   serial stream qualified by bit_in_valid (gaps allowed). A completed word
//   appears on data_out with a one-cycle data_out_valid strobe, one clock
//   after its last bit. No backpressure.
//
//   Build option: define BITSTREAM_RX_TIMEOUT_EN to abort a partial word
//   after TIMEOUT_CYCLES consecutive idle cycles and flag it on frame_err.
//   Without it, frame_err is tied low and a partial word waits forever.
//
// Ports
//   clk             in   clock, posedge
//   rst             in   synchronous, active-high reset
//   bit_in          in   serial data bit
//   bit_in_valid    in   bit_in is valid this cycle
//   data_out        out  last completed word (held between strobes)
//   data_out_valid  out  one-cycle strobe: data_out is new
//   frame_err       out  one-cycle strobe: partial word dropped on timeout
//
// States
//   state       | meaning
//   ST_RST      | first cycle out of reset; input ignored
//   ST_IDLE     | waiting for bit 0 of a word
//   ST_COLLECT  | bits 1..OUT_SIZE-1 of the current word being gathered
// -----------------------------------------------------------------------------
module bitstream_to_byte
    import bitstream_pkg::*;
#(
    parameter int OUT_SIZE = BITSTREAM_WORD
`ifdef BITSTREAM_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bit_in,
    input  logic                bit_in_valid,
    output logic [OUT_SIZE-1:0] data_out,
    output logic                data_out_valid,
    output logic                frame_err
);

    localparam int CNT_W = $clog2(OUT_SIZE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUT_SIZE - 1);

    logic [3:0]          state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [OUT_SIZE-1:0] shreg_q, shreg_d;
    logic [OUT_SIZE-1:0] data_q, data_d;
    logic                valid_q, valid_d;

    // Shift register with the incoming bit already inserted; on the last bit
    // this is the finished word, so it can go straight to the output register.
    logic [CNT_W-1:0]    ins_idx;
    logic [OUT_SIZE-1:0] word_ins;

`ifdef BITSTREAM_RX_TIMEOUT_EN
    logic gap_en;
    logic gap_tc;
    logic ferr_q, ferr_d;

    // Idle cycles are only counted mid-word; any valid bit or any other state
    // reloads the timer.
    assign gap_en = (state_q == ST_COLLECT) && !bit_in_valid;

    bitstream_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk  (clk),
        .rst  (rst),
        .clr_i(!gap_en),
        .en_i (gap_en),
        .tc_o (gap_tc)
    );
`endif

    always_comb begin
        ins_idx = (state_q == ST_COLLECT) ? count_q : '0;
        word_ins = shreg_q;
        word_ins[ins_idx] = bit_in;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
`ifdef BITSTREAM_RX_TIMEOUT_EN
        ferr_d  = 1'b0;
`endif
        case (state_q)
            ST_RST: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
            ST_IDLE: begin
                if (bit_in_valid) begin
                    shreg_d = word_ins;
                    count_d = CNT_W'(1);
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (bit_in_valid) begin
                    shreg_d = word_ins;
                    if (count_q == LAST_IDX) begin
                        count_d = '0;
                        state_d = ST_IDLE;
                        data_d  = word_ins;
                        valid_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
`ifdef BITSTREAM_RX_TIMEOUT_EN
                else if (gap_tc) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RST;
            count_q <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;

`ifdef BITSTREAM_RX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
        end
    end

    assign frame_err = ferr_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule : bitstream_to_byte

// File: tb/tb_bitstream_to_byte.sv
// -----------------------------------------------------------------------------
// tb_bitstream_to_byte
//   Directed bench for bitstream_to_byte (OUT_SIZE=8). Inputs change 1 ns
//   after the rising edge; outputs are sampled at the same point, so each
//   sample shows the effect of the edge just taken.
// -----------------------------------------------------------------------------
module tb_bitstream_to_byte;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_in_valid = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int strobes = 0;
    int ferrs = 0;
    int last_strobe = 0;

    always #5 clk = ~clk;

    bitstream_to_byte dut (
        .clk           (clk),
        .rst           (rst),
        .bit_in        (bit_in),
        .bit_in_valid  (bit_in_valid),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .frame_err     (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, then record any strobes.
    task automatic cyc(input logic b, input logic v);
        bit_in       = b;
        bit_in_valid = v;
        @(posedge clk);
        #1;
        cyc_n++;
        if (data_out_valid === 1'b1) begin
            strobes++;
            last_strobe = cyc_n;
        end
        if (frame_err === 1'b1) ferrs++;
    endtask

    // LSB first; optional idle gap (random bit_in, valid low) after bit gap_after.
    task automatic send_word(input logic [7:0] w, input int gap_after, input int gap_len);
        for (int i = 0; i < 8; i++) begin
            cyc(w[i], 1'b1);
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) cyc(1'($urandom_range(0, 1)), 1'b0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset holds all outputs low whatever the inputs do
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check("rst_data", data_out, 8'h00);
            check("rst_valid", data_out_valid, 1'b0);
            check("rst_ferr", frame_err, 1'b0);
        end
        rst = 1'b0;
        // First cycle out of reset: this valid bit must be ignored.
        cyc(1'b1, 1'b1);
        check("rst_exit_valid", data_out_valid, 1'b0);

        // 2: single word A5, strobe the cycle after bit 8, one cycle only
        strobes = 0;
        send_word(8'hA5, -1, 0);
        check("a5_valid", data_out_valid, 1'b1);
        check("a5_data", data_out, 8'hA5);
        check("a5_strobes", strobes, 1);
        cyc(1'b0, 1'b0);
        check("a5_valid_drop", data_out_valid, 1'b0);
        check("a5_data_hold", data_out, 8'hA5);

        // 3: back-to-back 3C, C3
        strobes = 0;
        send_word(8'h3C, -1, 0);
        check("b2b_first_valid", data_out_valid, 1'b1);
        check("b2b_first_data", data_out, 8'h3C);
        begin
            int first_strobe;
            first_strobe = last_strobe;
            send_word(8'hC3, -1, 0);
            check("b2b_second_data", data_out, 8'hC3);
            check("b2b_spacing", last_strobe - first_strobe, 8);
        end
        cyc(1'b0, 1'b0);
        check("b2b_strobes", strobes, 2);

        // 4: 5A with a 3-cycle gap after bit 3
        strobes = 0;
        send_word(8'h5A, 2, 3);
        check("gap_valid", data_out_valid, 1'b1);
        check("gap_data", data_out, 8'h5A);
        check("gap_strobes", strobes, 1);

        // 5: reset in the middle of a word drops it
        strobes = 0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        check("midrst_data", data_out, 8'h00);
        rst = 1'b0;
        cyc(1'b0, 1'b0);
        send_word(8'hFF, -1, 0);
        check("midrst_data_ff", data_out, 8'hFF);
        check("midrst_strobes", strobes, 1);

`ifdef BITSTREAM_RX_TIMEOUT_EN
        // 6 (timeout build): 3 bits then 16 idle aborts the word
        strobes = 0;
        ferrs = 0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0);
        check("to_no_early_ferr", ferrs, 0);
        cyc(1'b0, 1'b0);
        check("to_ferr", frame_err, 1'b1);
        cyc(1'b0, 1'b0);
        check("to_ferr_drop", frame_err, 1'b0);
        check("to_no_strobe", strobes, 0);
        check("to_data_hold", data_out, 8'hFF);
        send_word(8'h81, -1, 0);
        check("to_next_data", data_out, 8'h81);
        check("to_next_strobes", strobes, 1);
        // A valid bit in the would-be timeout cycle keeps the word alive.
        strobes = 0;
        ferrs = 0;
        send_word(8'h42, 1, 15);
        check("to_edge_data", data_out, 8'h42);
        check("to_edge_strobes", strobes, 1);
        check("to_edge_ferrs", ferrs, 0);
`else
        // 6 (default build): a long gap never aborts the word
        strobes = 0;
        ferrs = 0;
        send_word(8'h96, 2, 100);
        check("long_gap_data", data_out, 8'h96);
        check("long_gap_strobes", strobes, 1);
        check("long_gap_ferrs", ferrs, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bitstream_to_byte
